// File: rtl/riscv_pkg.sv
// RV32I encoding constants shared by the instruction encoder and its packer.
// Opcodes, class/alu_op enumerations (alu_op values match the core decoder)
// and funct7 constants, plus the alu_op -> funct3 mapping.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_NORM = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // addi x0,x0,0 -- emitted for an unknown class
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_LUI    = 3'd5,
    CLS_JAL    = 3'd6
  } class_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_AND  = 4'd8,
    ALU_SUB  = 4'd9
  } alu_op_e;

  // funct3 for an ALU operation; out-of-range codes fall back to add
  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    logic [2:0] f3;
    case (op)
      ALU_SLL:          f3 = 3'b001;
      ALU_SLT:          f3 = 3'b010;
      ALU_SLTU:         f3 = 3'b011;
      ALU_XOR:          f3 = 3'b100;
      ALU_SRL, ALU_SRA: f3 = 3'b101;
      ALU_OR:           f3 = 3'b110;
      ALU_AND:          f3 = 3'b111;
      default:          f3 = 3'b000;
    endcase
    return f3;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Purely combinational packer: decoded control fields -> RV32I word,
// plus a flag marking requests that have no legal encoding.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  cls_i,
  input  logic [3:0]  alu_op_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic [2:0] alu_f3;
  logic [6:0] r_funct7;
  logic       is_shift;

  assign alu_f3   = alu_funct3(alu_op_i);
  assign r_funct7 = (alu_op_i == ALU_SUB || alu_op_i == ALU_SRA) ? FUNCT7_ALT : FUNCT7_NORM;
  assign is_shift = (alu_op_i == ALU_SLL) || (alu_op_i == ALU_SRL) || (alu_op_i == ALU_SRA);

  // Field placement per instruction format; unused fields never reach the word
  always_comb begin
    instr_o = NOP_WORD;
    case (cls_i)
      CLS_R:      instr_o = {r_funct7, rs2_i, rs1_i, alu_f3, rd_i, OPC_R};
      CLS_I: begin
        if (is_shift)
          instr_o = {(alu_op_i == ALU_SRA) ? FUNCT7_ALT : FUNCT7_NORM,
                     imm_i[4:0], rs1_i, alu_f3, rd_i, OPC_I};
        else
          instr_o = {imm_i[11:0], rs1_i, alu_f3, rd_i, OPC_I};
      end
      CLS_LOAD:   instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
      CLS_STORE:  instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
      CLS_BRANCH: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], OPC_BRANCH};
      CLS_LUI:    instr_o = {imm_i[31:12], rd_i, OPC_LUI};
      CLS_JAL:    instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
      default:    instr_o = NOP_WORD;
    endcase
  end

  // Requests with no legal RV32I encoding
  always_comb begin
    illegal_o = 1'b0;
    if (cls_i > 3'd6 || alu_op_i > 4'd9)
      illegal_o = 1'b1;
    else begin
      case (cls_i)
        CLS_I:      illegal_o = (alu_op_i == ALU_SUB);
        CLS_LOAD:   illegal_o = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
        CLS_STORE:  illegal_o = (funct3_i > 3'd2);
        CLS_BRANCH: illegal_o = (funct3_i == 3'd2) || (funct3_i == 3'd3);
        default:    illegal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded fields into an RV32I word and streams it
// through a DEPTH-entry valid/ready queue. The head word sits in a register so
// it is stable under backpressure and holds its last value when empty.
// Optional feature macro: INSTR_ENCODER_ILLEGAL_EN -- drop illegal requests
// (still accepted) and pulse err_pulse the cycle after acceptance.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_class,
  input  logic [3:0]  in_alu_op,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_pulse
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   head_q, head_d;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        accept, push, pop;

  instr_pack u_pack (
    .cls_i     (in_class),
    .alu_op_i  (in_alu_op),
    .funct3_i  (in_funct3),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .imm_i     (in_imm),
    .instr_o   (pack_word),
    .illegal_o (pack_illegal)
  );

  // in_ready depends only on registered count, never on out_ready
  assign in_ready  = (count_q != (PW+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_instr = head_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef INSTR_ENCODER_ILLEGAL_EN
  logic err_q;
  assign push      = accept & ~pack_illegal;
  assign err_pulse = err_q;

  // One-cycle flag for an accepted-but-dropped illegal request
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= accept & pack_illegal;
  end
`else
  logic unused_illegal;
  assign unused_illegal = pack_illegal;
  assign push           = accept;
  assign err_pulse      = 1'b0;
`endif

  // Pointer/count next state and the word that will be at the head next cycle
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (!push && pop) count_d = count_q - (PW+1)'(1);
    head_d = head_q;
    if (count_d != '0) begin
      // a pushed word lands on the new head slot only when it is the sole entry
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = pack_word;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  // Queue control state; reset flushes all entries and clears the head word
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Per-entry storage writes; contents are don't-care until pushed
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PW'(gi))) mem_q[gi] <= pack_word;
      end
    end
  endgenerate

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, backpressure,
// illegal-request handling, reset flush, then randomized traffic checked
// against a field-arithmetic reference model and a queue scoreboard.
module tb_instr_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [3:0]  in_alu_op;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_alu_op (in_alu_op),
    .in_funct3 (in_funct3),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

`ifdef INSTR_ENCODER_ILLEGAL_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int cls, input int op, input int f3, input int rd,
                         input int rs1, input int rs2, input logic [31:0] imm);
    in_class  = 3'(cls);
    in_alu_op = 4'(op);
    in_funct3 = 3'(f3);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
  endtask

  // Reference: build the word from field values with shifts and masks
  function automatic logic [31:0] ref_encode(input logic [31:0] cls, input logic [31:0] op,
                                             input logic [31:0] f3, input logic [31:0] rd,
                                             input logic [31:0] rs1, input logic [31:0] rs2,
                                             input logic [31:0] imm);
    logic [31:0] tab [10];
    logic [31:0] e, w, f7;
    tab = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd5, 32'd6, 32'd7, 32'd0};
    e = (op > 9) ? 32'd0 : op;
    case (cls)
      0: begin
        f7 = (e == 9 || e == 6) ? 32'h20 : 32'h0;
        w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (tab[e] << 12) | (rd << 7) | 32'h33;
      end
      1: begin
        if (e == 1 || e == 5 || e == 6)
          w = (((e == 6) ? 32'h20 : 32'h0) << 25) | ((imm & 32'h1f) << 20)
            | (rs1 << 15) | (tab[e] << 12) | (rd << 7) | 32'h13;
        else
          w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (tab[e] << 12) | (rd << 7) | 32'h13;
      end
      2: w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      3: w = (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((imm & 32'h1f) << 7) | 32'h23;
      4: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20)
           | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hf) << 8)
           | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      5: w = (imm & 32'hfffff000) | (rd << 7) | 32'h37;
      6: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
           | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000ff000) | (rd << 7) | 32'h6f;
      default: w = 32'h13;
    endcase
    return w;
  endfunction

  function automatic bit ref_illegal(input int cls, input int op, input int f3);
    if (cls > 6 || op > 9) return 1'b1;
    if (cls == 1 && op == 9) return 1'b1;
    if (cls == 2 && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (cls == 3 && f3 > 2) return 1'b1;
    if (cls == 4 && (f3 == 2 || f3 == 3)) return 1'b1;
    return 1'b0;
  endfunction

  // Single request with a free consumer: latency 1, popped on the next edge
  task automatic send_one(input string tag, input logic [31:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, out_instr, exp);
    tick();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] last_head;
  bit          exp_err;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 32'h0);
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_err", 32'(err_pulse), 32'd0);
    reset = 1'b0;
    tick();

    set_req(0, 0, 0, 3, 1, 2, 32'h0);        send_one("add", 32'h002081B3);
    set_req(0, 9, 0, 3, 1, 2, 32'h0);        send_one("sub", 32'h402081B3);
    set_req(1, 0, 0, 5, 0, 0, 32'hFFFFFFFF); send_one("addi", 32'hFFF00293);
    set_req(1, 6, 0, 5, 1, 0, 32'd3);        send_one("srai", 32'h4030D293);
    set_req(3, 0, 2, 0, 1, 2, 32'd8);        send_one("sw", 32'h0020A423);
    set_req(4, 0, 0, 0, 1, 2, 32'd8);        send_one("beq", 32'h00208463);
    set_req(5, 0, 0, 5, 0, 0, 32'h12345000); send_one("lui", 32'h123452B7);

    // Illegal branch funct3=2
    set_req(4, 0, 2, 0, 1, 2, 32'd8);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    check("ill_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    if (CHECK_EN) begin
      check("ill_err", 32'(err_pulse), 32'd1);
      check("ill_not_queued", 32'(out_valid), 32'd0);
      tick();
      check("ill_err_clear", 32'(err_pulse), 32'd0);
    end else begin
      check("ill_err_tied", 32'(err_pulse), 32'd0);
      check("ill_queued", 32'(out_valid), 32'd1);
      check("ill_word", out_instr, 32'h0020A463);
      tick();
    end

    // Backpressure: three offered, two taken
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(0, 4, 0, 1, 2, 3, 32'h0);  // A: xor
    tick();
    set_req(0, 7, 0, 4, 5, 6, 32'h0);  // B: or
    tick();
    set_req(0, 8, 0, 7, 8, 9, 32'h0);  // C: and
    check("bp_full", 32'(in_ready), 32'd0);
    check("bp_head", out_instr, ref_encode(0, 4, 0, 1, 2, 3, 0));
    tick();
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_stable", out_instr, ref_encode(0, 4, 0, 1, 2, 3, 0));
    out_ready = 1'b1;
    tick();
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_second", out_instr, ref_encode(0, 7, 0, 4, 5, 6, 0));
    tick();
    in_valid = 1'b0;
    check("bp_third", out_instr, ref_encode(0, 8, 0, 7, 8, 9, 0));
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_hold_last", out_instr, ref_encode(0, 8, 0, 7, 8, 9, 0));

    // Reset with two entries queued
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(5, 0, 0, 1, 0, 0, 32'hABCDE000); tick();
    set_req(5, 0, 0, 2, 0, 0, 32'h13579000); tick();
    in_valid = 1'b0;
    check("pre_flush_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_instr", out_instr, 32'h0);

    // Randomized traffic vs scoreboard
    last_head = 32'h0;
    exp_err   = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      int cls, op, f3, rd, rs1, rs2;
      logic [31:0] imm;
      bit acc, ill;
      cls = $urandom_range(0, 7);
      op  = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      f3  = $urandom_range(0, 7);
      rd  = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      imm = $urandom;
      set_req(cls, op, f3, rd, rs1, rs2, imm);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      check("rnd_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("rnd_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      check("rnd_err", 32'(err_pulse), 32'(exp_err));
      if (exp_q.size() != 0) begin
        check("rnd_word", out_instr, exp_q[0]);
        last_head = exp_q[0];
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        check("rnd_hold", out_instr, last_head);
      end
      acc = in_valid && (exp_q.size() != DEPTH || (out_ready && 0));
      ill = ref_illegal(cls, op, f3);
      acc = in_valid && ((exp_q.size() + ((out_valid && out_ready) ? 1 : 0)) != DEPTH);
      if (acc && !(CHECK_EN && ill))
        exp_q.push_back(ref_encode(cls, op, f3, rd, rs1, rs2, imm));
      exp_err = CHECK_EN && acc && ill;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
